// File: rtl/gemm_pkg.sv
// Shared defaults, FSM encoding and flattening helper for the GEMM operand loader.
// Defining GEMM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word to every frame.
package gemm_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int MATRIX_HEIGHT = 4;
  localparam int MATRIX_WIDTH  = 4;
  localparam int N_ELEM        = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int COUNT_WIDTH   = 10;

`ifdef GEMM_LOADER_CHECKSUM_EN
  localparam int FRAME_WORDS = 3 * N_ELEM + 3;
`else
  localparam int FRAME_WORDS = 3 * N_ELEM + 2;
`endif

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_C  = 3'd2,
    LOAD_SC = 3'd3,
`ifdef GEMM_LOADER_CHECKSUM_EN
    LOAD_CK = 3'd4,
`endif
    HOLD    = 3'd5
  } state_t;

  function automatic int elem_idx(input int i, input int j);
    return i * MATRIX_WIDTH + j;
  endfunction

endpackage

// File: rtl/gemm_frame_counter.sv
// Word counter for one operand frame plus decode of which region the current word lands in.
// With GEMM_LOADER_CHECKSUM_EN the trailing checksum word is flagged by is_ck.
module gemm_frame_counter #(
  parameter int ELEMS  = gemm_pkg::N_ELEM,
  parameter int ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              clear,
  output logic [ELEM_W-1:0] elem,
  output logic              is_a,
  output logic              is_b,
  output logic              is_c,
  output logic              is_alpha,
  output logic              is_beta,
`ifdef GEMM_LOADER_CHECKSUM_EN
  output logic              is_ck,
  output logic              is_first,
`endif
  output logic              is_final
);
  import gemm_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] B_BASE    = COUNT_WIDTH'(ELEMS);
  localparam logic [COUNT_WIDTH-1:0] C_BASE    = COUNT_WIDTH'(2 * ELEMS);
  localparam logic [COUNT_WIDTH-1:0] ALPHA_POS = COUNT_WIDTH'(3 * ELEMS);
  localparam logic [COUNT_WIDTH-1:0] BETA_POS  = COUNT_WIDTH'(3 * ELEMS + 1);
`ifdef GEMM_LOADER_CHECKSUM_EN
  localparam logic [COUNT_WIDTH-1:0] CK_POS    = COUNT_WIDTH'(3 * ELEMS + 2);
  localparam logic [COUNT_WIDTH-1:0] FINAL_POS = CK_POS;
`else
  localparam logic [COUNT_WIDTH-1:0] FINAL_POS = BETA_POS;
`endif

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (beat) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  assign is_a     = (count < B_BASE);
  assign is_b     = (count >= B_BASE) && (count < C_BASE);
  assign is_c     = (count >= C_BASE) && (count < ALPHA_POS);
  assign is_alpha = (count == ALPHA_POS);
  assign is_beta  = (count == BETA_POS);
  assign is_final = (count == FINAL_POS);
`ifdef GEMM_LOADER_CHECKSUM_EN
  assign is_ck    = (count == CK_POS);
  assign is_first = (count == '0);
`endif

  // Element index within the current matrix block (row-major position).
  always_comb begin
    elem = ELEM_W'(count);
    if (is_b) begin
      elem = ELEM_W'(count - B_BASE);
    end else if (is_c) begin
      elem = ELEM_W'(count - C_BASE);
    end
  end

endmodule

// File: rtl/gemm_operand_loader.sv
// Assembles one GEMM operand frame (A, B, C, alpha, beta) from a valid/ready stream and holds it for gemm_top.
// Optional GEMM_LOADER_CHECKSUM_EN appends an XOR checksum word that must match before the frame is presented.
module gemm_operand_loader #(
  parameter int DATA_WIDTH    = gemm_pkg::DATA_WIDTH,
  parameter int MATRIX_HEIGHT = gemm_pkg::MATRIX_HEIGHT,
  parameter int MATRIX_WIDTH  = gemm_pkg::MATRIX_WIDTH
) (
  input  logic                                          iclk,
  input  logic                                          irst,
  input  logic [DATA_WIDTH-1:0]                         s_data,
  input  logic                                          s_valid,
  input  logic                                          s_last,
  output logic                                          s_ready,
  output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] a_matrix,
  output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] b_matrix,
  output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] c_matrix,
  output logic [DATA_WIDTH-1:0]                         alpha,
  output logic [DATA_WIDTH-1:0]                         beta,
  output logic                                          operands_valid,
  input  logic                                          operands_ack,
  output logic                                          frame_err
);
  import gemm_pkg::*;

  localparam int ELEMS  = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(ELEMS - 1);

  state_t state, state_next;
  logic   ready;
  logic   beat;
  logic   abort;
  logic   clear;

  logic [ELEM_W-1:0] elem;
  logic is_a, is_b, is_c, is_alpha, is_beta, is_final;

  logic [DATA_WIDTH-1:0] a_mem [ELEMS];
  logic [DATA_WIDTH-1:0] b_mem [ELEMS];
  logic [DATA_WIDTH-1:0] c_mem [ELEMS];

  assign beat           = s_valid & ready;
  assign s_ready        = ready;
  assign operands_valid = (state == HOLD);
  assign clear          = abort | (beat & is_final);

`ifdef GEMM_LOADER_CHECKSUM_EN
  logic                  is_ck;
  logic                  is_first;
  logic [DATA_WIDTH-1:0] xor_acc;

  // The first data word reloads the accumulator, so aborted frames need no explicit flush.
  always_ff @(posedge iclk) begin
    if (irst) begin
      xor_acc <= '0;
    end else if (beat && !is_ck) begin
      xor_acc <= is_first ? s_data : (xor_acc ^ s_data);
    end
  end

  assign abort = beat & ((s_last != is_final) | (is_ck & (s_data != xor_acc)));
`else
  assign abort = beat & (s_last != is_final);
`endif

  gemm_frame_counter #(
    .ELEMS  (ELEMS),
    .ELEM_W (ELEM_W)
  ) u_counter (
    .clk      (iclk),
    .rst      (irst),
    .beat     (beat),
    .clear    (clear),
    .elem     (elem),
    .is_a     (is_a),
    .is_b     (is_b),
    .is_c     (is_c),
    .is_alpha (is_alpha),
    .is_beta  (is_beta),
`ifdef GEMM_LOADER_CHECKSUM_EN
    .is_ck    (is_ck),
    .is_first (is_first),
`endif
    .is_final (is_final)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int k = 0; k < ELEMS; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
        c_mem[k] <= '0;
      end
      alpha <= '0;
      beta  <= '0;
    end else if (beat) begin
      if (is_a)     a_mem[elem] <= s_data;
      if (is_b)     b_mem[elem] <= s_data;
      if (is_c)     c_mem[elem] <= s_data;
      if (is_alpha) alpha       <= s_data;
      if (is_beta)  beta        <= s_data;
    end
  end

  for (genvar k = 0; k < ELEMS; k++) begin : g_flat
    assign a_matrix[k*DATA_WIDTH +: DATA_WIDTH] = a_mem[k];
    assign b_matrix[k*DATA_WIDTH +: DATA_WIDTH] = b_mem[k];
    assign c_matrix[k*DATA_WIDTH +: DATA_WIDTH] = c_mem[k];
  end

  // s_ready is registered so it stays low for the whole first cycle after reset.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= LOAD_A;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      ready     <= (state_next != HOLD);
      frame_err <= abort;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (beat && elem == LAST_ELEM) state_next = LOAD_B;
      LOAD_B:  if (beat && elem == LAST_ELEM) state_next = LOAD_C;
      LOAD_C:  if (beat && elem == LAST_ELEM) state_next = LOAD_SC;
`ifdef GEMM_LOADER_CHECKSUM_EN
      LOAD_SC: if (beat && is_beta) state_next = LOAD_CK;
      LOAD_CK: if (beat) state_next = HOLD;
`else
      LOAD_SC: if (beat && is_beta) state_next = HOLD;
`endif
      HOLD:    if (operands_ack) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
    // Any framing or checksum error discards the partial frame.
    if (abort) state_next = LOAD_A;
  end

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Directed self-checking bench for gemm_operand_loader with hand-computed frame contents.
// Define GEMM_LOADER_CHECKSUM_EN to exercise the trailing XOR checksum word.
module tb_gemm_operand_loader;

  localparam int DW = 32;
  localparam int H  = 4;
  localparam int W  = 4;
`ifdef GEMM_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = 51;
`else
  localparam int FRAME_LEN = 50;
`endif

  logic              iclk = 1'b0;
  logic              irst;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DW*H*W-1:0] a_matrix;
  logic [DW*H*W-1:0] b_matrix;
  logic [DW*H*W-1:0] c_matrix;
  logic [DW-1:0]     alpha;
  logic [DW-1:0]     beta;
  logic              operands_valid;
  logic              operands_ack;
  logic              frame_err;

  int total = 0;
  int bad   = 0;

  gemm_operand_loader dut (
    .iclk           (iclk),
    .irst           (irst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .a_matrix       (a_matrix),
    .b_matrix       (b_matrix),
    .c_matrix       (c_matrix),
    .alpha          (alpha),
    .beta           (beta),
    .operands_valid (operands_valid),
    .operands_ack   (operands_ack),
    .frame_err      (frame_err)
  );

  always #5 iclk = ~iclk;

  function automatic logic [DW-1:0] elem_of(input logic [DW*H*W-1:0] m, input int i, input int j);
    return m[(i*W + j)*DW +: DW];
  endfunction

  // Word k (1-based) of a frame whose data words are base+1..base+50; word 51 is the XOR checksum.
  function automatic logic [DW-1:0] word_val(input int base, input int k, input bit flip);
    logic [DW-1:0] x;
    if (k <= 50) return DW'(base + k);
    x = '0;
    for (int i = 1; i <= 50; i++) x = x ^ DW'(base + i);
    return x ^ {31'b0, flip};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic l, input bit gap);
    int waited;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge iclk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    waited  = 0;
    while (!s_ready && waited < 20) begin
      @(posedge iclk); #1;
      waited++;
    end
    if (!s_ready) checkOutput("ready_timeout", {31'b0, s_ready}, 32'd1);
    else begin
      @(posedge iclk); #1;
    end
  endtask

  task automatic send_frame(input int base, input int last_pos, input int n_words, input bit gaps, input bit flip);
    for (int k = 1; k <= n_words; k++) begin
      applyStimulus(word_val(base, k, flip), (k == last_pos), gaps && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    checkOutput({tag, "_a00"},  elem_of(a_matrix, 0, 0), DW'(base + 1));
    checkOutput({tag, "_a33"},  elem_of(a_matrix, 3, 3), DW'(base + 16));
    checkOutput({tag, "_b00"},  elem_of(b_matrix, 0, 0), DW'(base + 17));
    checkOutput({tag, "_b12"},  elem_of(b_matrix, 1, 2), DW'(base + 23));
    checkOutput({tag, "_c21"},  elem_of(c_matrix, 2, 1), DW'(base + 42));
    checkOutput({tag, "_c33"},  elem_of(c_matrix, 3, 3), DW'(base + 48));
    checkOutput({tag, "_alpha"}, alpha, DW'(base + 49));
    checkOutput({tag, "_beta"},  beta,  DW'(base + 50));
  endtask

  task automatic pulse_ack();
    operands_ack = 1'b1;
    @(posedge iclk); #1;
    operands_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    irst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; operands_ack = 1'b0;
    repeat (3) @(posedge iclk);
    #1 irst = 1'b0;

    // Reset state, then s_ready rises one cycle later.
    checkOutput("rst_ready", {31'b0, s_ready}, 32'd0);
    checkOutput("rst_valid", {31'b0, operands_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, frame_err}, 32'd0);
    checkOutput("rst_a", {31'b0, |a_matrix}, 32'd0);
    checkOutput("rst_b", {31'b0, |b_matrix}, 32'd0);
    checkOutput("rst_c", {31'b0, |c_matrix}, 32'd0);
    checkOutput("rst_alpha", alpha, 32'd0);
    checkOutput("rst_beta", beta, 32'd0);
    @(posedge iclk); #1;
    checkOutput("rst_ready_rise", {31'b0, s_ready}, 32'd1);

    // Scenario 1: contiguous frame 1..50.
    send_frame(0, FRAME_LEN, FRAME_LEN - 1, 1'b0, 1'b0);
    checkOutput("s1_valid_early", {31'b0, operands_valid}, 32'd0);
    applyStimulus(word_val(0, FRAME_LEN, 1'b0), 1'b1, 1'b0);
    s_valid = 1'b0;
    checkOutput("s1_valid", {31'b0, operands_valid}, 32'd1);
    checkOutput("s1_ready", {31'b0, s_ready}, 32'd0);
    checkOutput("s1_err", {31'b0, frame_err}, 32'd0);
    check_frame("s1", 0);

    // Junk offered during HOLD must not disturb the held frame.
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; s_last = 1'b1;
    repeat (3) @(posedge iclk);
    #1 s_valid = 1'b0; s_last = 1'b0;
    checkOutput("hold_valid", {31'b0, operands_valid}, 32'd1);
    checkOutput("hold_err", {31'b0, frame_err}, 32'd0);
    check_frame("hold", 0);

    // Scenario 2: acknowledge, stray ack ignored, second frame.
    pulse_ack();
    checkOutput("s2_valid_drop", {31'b0, operands_valid}, 32'd0);
    checkOutput("s2_ready_up", {31'b0, s_ready}, 32'd1);
    pulse_ack();
    checkOutput("s2_stray_valid", {31'b0, operands_valid}, 32'd0);
    checkOutput("s2_stray_ready", {31'b0, s_ready}, 32'd1);
    send_frame(100, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("s2_valid", {31'b0, operands_valid}, 32'd1);
    check_frame("s2", 100);

    // Scenario 3: early s_last on word 20, then a good frame.
    pulse_ack();
    send_frame(200, 20, 20, 1'b0, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("s3_err", {31'b0, frame_err}, 32'd1);
    checkOutput("s3_valid", {31'b0, operands_valid}, 32'd0);
    @(posedge iclk); #1;
    checkOutput("s3_err_pulse", {31'b0, frame_err}, 32'd0);
    checkOutput("s3_ready", {31'b0, s_ready}, 32'd1);
    send_frame(300, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("s3_good_valid", {31'b0, operands_valid}, 32'd1);
    check_frame("s3", 300);

    // Scenario 4: final word without s_last.
    pulse_ack();
    send_frame(400, 0, FRAME_LEN, 1'b0, 1'b0);
    s_valid = 1'b0;
    checkOutput("s4_err", {31'b0, frame_err}, 32'd1);
    checkOutput("s4_valid", {31'b0, operands_valid}, 32'd0);
    checkOutput("s4_ready", {31'b0, s_ready}, 32'd1);
    @(posedge iclk); #1;
    checkOutput("s4_valid_after", {31'b0, operands_valid}, 32'd0);

    // Scenario 5: frame 1..50 with random valid gaps.
    send_frame(0, FRAME_LEN, FRAME_LEN, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("s5_valid", {31'b0, operands_valid}, 32'd1);
    checkOutput("s5_err", {31'b0, frame_err}, 32'd0);
    check_frame("s5", 0);

    // Scenario 6: reset during HOLD with an ack in flight.
    irst = 1'b1; operands_ack = 1'b1;
    @(posedge iclk); #1;
    irst = 1'b0; operands_ack = 1'b0;
    checkOutput("s6_valid", {31'b0, operands_valid}, 32'd0);
    checkOutput("s6_ready", {31'b0, s_ready}, 32'd0);
    checkOutput("s6_a", {31'b0, |a_matrix}, 32'd0);
    checkOutput("s6_alpha", alpha, 32'd0);
    checkOutput("s6_beta", beta, 32'd0);
    @(posedge iclk); #1;
    checkOutput("s6_ready_rise", {31'b0, s_ready}, 32'd1);

`ifdef GEMM_LOADER_CHECKSUM_EN
    // Corrupted checksum word is rejected.
    send_frame(600, FRAME_LEN, FRAME_LEN, 1'b0, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("ck_err", {31'b0, frame_err}, 32'd1);
    checkOutput("ck_valid", {31'b0, operands_valid}, 32'd0);
    send_frame(700, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("ck_good_valid", {31'b0, operands_valid}, 32'd1);
    check_frame("ck", 700);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
